// File: rtl/onehot_req_sched_if.sv
// Request/grant bundle between the request source, the scheduler and the 8:3 encoder.
// The master side drives requests, mask and ready; the slave side (scheduler) returns the one-hot pick.
interface onehot_req_sched_if;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       out_ready;
  logic [7:0] onehot_out;
  logic       out_valid;
  logic [7:0] pending;
  logic [3:0] pend_cnt;

  modport master (
    output req_in, mask, out_ready,
    input  onehot_out, out_valid, pending, pend_cnt
  );

  modport slave (
    input  req_in, mask, out_ready,
    output onehot_out, out_valid, pending, pend_cnt
  );
endinterface

// File: rtl/onehot_req_sched.sv
// Sticky request capture with round-robin or fixed-priority pick, presented as a
// registered strictly one-hot vector under valid/ready for the 8:3 encoder.
module onehot_req_sched #(
  parameter int N  = 8,
  parameter bit RR = 1'b1
) (
  input logic              clk,
  input logic              rst,
  onehot_req_sched_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  pend_p0;
  logic [N-1:0]  onehot_p0;
  logic          vld_p0;
  logic [IW-1:0] ptr_p0;

  logic          hs;
  logic          load;
  logic [N-1:0]  clr;
  logic [N-1:0]  pend_next;
  logic [N-1:0]  eligible;
  logic [N-1:0]  pick_vec;
  logic [IW-1:0] acc_idx;
  logic [IW-1:0] acc_next;
  logic [IW-1:0] search_base;

  function automatic logic [IW-1:0] encode(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) idx = IW'(i);
    return idx;
  endfunction

  // Walks offsets high to low so the last hit kept is the nearest to base.
  function automatic logic [N-1:0] pick(input logic [N-1:0] elig, input logic [IW-1:0] base);
    logic [N-1:0]  res;
    logic [IW-1:0] idx;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = base + IW'(i);
      if (elig[idx]) begin
        res      = '0;
        res[idx] = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++)
      cnt = cnt + CW'(v[i]);
    return cnt;
  endfunction

  always_comb begin
    hs          = vld_p0 & bus.out_ready;
    clr         = hs ? onehot_p0 : '0;
    pend_next   = (pend_p0 & ~clr) | bus.req_in;
    load        = ~vld_p0 | hs;
    eligible    = pend_next & bus.mask;
    acc_idx     = encode(onehot_p0);
    acc_next    = acc_idx + IW'(1);
    // A reload on handshake searches from the advanced pointer, so the
    // bit just granted goes to the back of the queue in the same edge.
    search_base = RR ? (hs ? acc_next : ptr_p0) : '0;
    pick_vec    = pick(eligible, search_base);
  end

  // ---- output stage p0 ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_p0   <= '0;
      onehot_p0 <= '0;
      vld_p0    <= 1'b0;
      ptr_p0    <= '0;
    end else begin
      pend_p0 <= pend_next;
      if (load) begin
        onehot_p0 <= pick_vec;
        vld_p0    <= |eligible;
      end
      if (hs)
        ptr_p0 <= acc_next;
    end
  end

  assign bus.onehot_out = onehot_p0;
  assign bus.out_valid  = vld_p0;
  assign bus.pending    = pend_p0;
  assign bus.pend_cnt   = popcount(pend_p0);
endmodule

// File: tb/tb_onehot_req_sched.sv
// Bench for onehot_req_sched: directed scenarios plus randomized traffic against
// an index-based reference model, for both round-robin and fixed-priority builds.
module tb_onehot_req_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] msk;
  logic       rdy;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  onehot_req_sched_if if_rr ();
  onehot_req_sched_if if_fp ();

  assign if_rr.req_in    = req;
  assign if_rr.mask      = msk;
  assign if_rr.out_ready = rdy;
  assign if_fp.req_in    = req;
  assign if_fp.mask      = msk;
  assign if_fp.out_ready = rdy;

  onehot_req_sched #(.N(8), .RR(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr));
  onehot_req_sched #(.N(8), .RR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(if_fp));

  // Reference: pending as a bit set, grant as an index (-1 = nothing presented).
  typedef struct packed {
    logic [7:0] pend;
    int         gnt;
    int         ptr;
  } mstate_t;

  mstate_t m_rr = '{pend: 8'h00, gnt: -1, ptr: 0};
  mstate_t m_fp = '{pend: 8'h00, gnt: -1, ptr: 0};

  function automatic mstate_t model_next(input mstate_t s, input bit rr, input logic r,
                                         input logic [7:0] rq, input logic [7:0] mk, input logic rd);
    mstate_t n;
    bit      accept;
    int      b;
    n = s;
    if (r) begin
      n.pend = 8'h00;
      n.gnt  = -1;
      n.ptr  = 0;
      return n;
    end
    accept = (s.gnt >= 0) && rd;
    if (accept) begin
      n.pend[s.gnt] = 1'b0;
      n.ptr = (s.gnt + 1) % 8;
    end
    n.pend = n.pend | rq;
    if (s.gnt < 0 || accept) begin
      n.gnt = -1;
      for (int j = 0; j < 8; j++) begin
        b = rr ? (n.ptr + j) % 8 : j;
        if (n.gnt < 0 && n.pend[b] && mk[b]) n.gnt = b;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_rr <= model_next(m_rr, 1'b1, rst, req, msk, rdy);
    m_fp <= model_next(m_fp, 1'b0, rst, req, msk, rdy);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; msk = 8'hFF; rdy = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF; msk = 8'hFF; rdy = 1'b1;
    cyc(); cyc();
    total++;
    if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pending, if_rr.pend_cnt} !== {1'b0, 8'h00, 8'h00, 4'd0}) begin
      bad++;
      $display("FAIL reset_rr got v=%b oh=%h p=%h c=%0d want 0", if_rr.out_valid, if_rr.onehot_out, if_rr.pending, if_rr.pend_cnt);
    end
    total++;
    if ({if_fp.out_valid, if_fp.onehot_out, if_fp.pending} !== {1'b0, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_fp got v=%b oh=%h p=%h want 0", if_fp.out_valid, if_fp.onehot_out, if_fp.pending);
    end
    rst = 1'b0; req = 8'h00; rdy = 1'b0;
    cyc(); cyc();
    total++;
    if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pending} !== {1'b0, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_idle got v=%b oh=%h p=%h want 0", if_rr.out_valid, if_rr.onehot_out, if_rr.pending);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h10;
    cyc();
    req = 8'h00;
    total++;
    if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pend_cnt} !== {1'b1, 8'h10, 4'd1}) begin
      bad++;
      $display("FAIL single_load got v=%b oh=%h c=%0d want v=1 oh=10 c=1", if_rr.out_valid, if_rr.onehot_out, if_rr.pend_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pending} !== {1'b1, 8'h10, 8'h10}) begin
        bad++;
        $display("FAIL single_hold%0d got v=%b oh=%h p=%h want v=1 oh=10 p=10", i, if_rr.out_valid, if_rr.onehot_out, if_rr.pending);
      end
    end
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    total++;
    if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pending, if_rr.pend_cnt} !== {1'b0, 8'h00, 8'h00, 4'd0}) begin
      bad++;
      $display("FAIL single_accept got v=%b oh=%h p=%h c=%0d want all 0", if_rr.out_valid, if_rr.onehot_out, if_rr.pending, if_rr.pend_cnt);
    end
  endtask

  task automatic test_rr_fair();
    logic [7:0] exp_gnt [5] = '{8'h01, 8'h80, 8'h01, 8'h80, 8'h01};
    logic [2:0] exp_ptr [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
    do_reset();
    req = 8'h81; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if ({if_rr.out_valid, if_rr.onehot_out, dut_rr.ptr_p0} !== {1'b1, exp_gnt[i], exp_ptr[i]}) begin
        bad++;
        $display("FAIL rr_fair%0d got v=%b oh=%h ptr=%0d want v=1 oh=%h ptr=%0d", i, if_rr.out_valid, if_rr.onehot_out, dut_rr.ptr_p0, exp_gnt[i], exp_ptr[i]);
      end
      total++;
      if (if_fp.onehot_out !== 8'h01) begin
        bad++;
        $display("FAIL fp_starve%0d got oh=%h want 01", i, if_fp.onehot_out);
      end
    end
    req = 8'h00; rdy = 1'b0;
  endtask

  task automatic test_fixed();
    logic [8:0] exp_seq [3] = '{{1'b1, 8'h04}, {1'b1, 8'h08}, {1'b0, 8'h00}};
    do_reset();
    req = 8'h0C; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      req = 8'h00;
      total++;
      if ({if_fp.out_valid, if_fp.onehot_out} !== exp_seq[i]) begin
        bad++;
        $display("FAIL fixed%0d got %h want %h", i, {if_fp.out_valid, if_fp.onehot_out}, exp_seq[i]);
      end
    end
    rdy = 1'b0;
  endtask

  task automatic test_mask_stall();
    do_reset();
    req = 8'h22;
    cyc();
    req = 8'h00; msk = 8'h20;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({if_rr.out_valid, if_rr.onehot_out, if_fp.onehot_out} !== {1'b1, 8'h02, 8'h02}) begin
        bad++;
        $display("FAIL stall_hold%0d got rr=%h fp=%h v=%b want 02", i, if_rr.onehot_out, if_fp.onehot_out, if_rr.out_valid);
      end
    end
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    total++;
    if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pending, if_fp.onehot_out} !== {1'b1, 8'h20, 8'h20, 8'h20}) begin
      bad++;
      $display("FAIL stall_next got v=%b rr=%h p=%h fp=%h want 20", if_rr.out_valid, if_rr.onehot_out, if_rr.pending, if_fp.onehot_out);
    end
    rdy = 1'b1;
    cyc();
    rdy = 1'b0; msk = 8'h00; req = 8'h40;
    cyc();
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pending} !== {1'b0, 8'h00, 8'h40}) begin
        bad++;
        $display("FAIL masked_only%0d got v=%b oh=%h p=%h want v=0 oh=00 p=40", i, if_rr.out_valid, if_rr.onehot_out, if_rr.pending);
      end
    end
    msk = 8'h40;
    cyc();
    total++;
    if ({if_rr.out_valid, if_rr.onehot_out} !== {1'b1, 8'h40}) begin
      bad++;
      $display("FAIL mask_open got v=%b oh=%h want v=1 oh=40", if_rr.out_valid, if_rr.onehot_out);
    end
    rdy = 1'b1; msk = 8'hFF;
    cyc();
    rdy = 1'b0;
  endtask

  task automatic test_set_wins();
    int grants;
    do_reset();
    req = 8'h04;
    cyc();
    rdy = 1'b1;
    cyc();
    req = 8'h00; rdy = 1'b0;
    total++;
    if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pending} !== {1'b1, 8'h04, 8'h04}) begin
      bad++;
      $display("FAIL set_wins got v=%b oh=%h p=%h want v=1 oh=04 p=04", if_rr.out_valid, if_rr.onehot_out, if_rr.pending);
    end
    rdy = 1'b1;
    cyc();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = 8'h04;
      cyc();
      req = 8'h00;
      cyc();
    end
    total++;
    if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pend_cnt} !== {1'b1, 8'h04, 4'd1}) begin
      bad++;
      $display("FAIL coalesce_pend got v=%b oh=%h c=%0d want v=1 oh=04 c=1", if_rr.out_valid, if_rr.onehot_out, if_rr.pend_cnt);
    end
    grants = 0;
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (if_rr.out_valid) grants++;
      cyc();
    end
    rdy = 1'b0;
    total++;
    if (grants !== 1) begin
      bad++;
      $display("FAIL coalesce_grants got %0d want 1", grants);
    end
  endtask

  task automatic test_random();
    logic [7:0] e_rr;
    logic [7:0] e_fp;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      e_rr = (m_rr.gnt >= 0) ? (8'h01 << m_rr.gnt) : 8'h00;
      e_fp = (m_fp.gnt >= 0) ? (8'h01 << m_fp.gnt) : 8'h00;
      total++;
      if ({if_rr.out_valid, if_rr.onehot_out, if_rr.pending, if_rr.pend_cnt} !==
          {(m_rr.gnt >= 0), e_rr, m_rr.pend, 4'($countones(m_rr.pend))}) begin
        bad++;
        $display("FAIL rand_rr cyc=%0d got v=%b oh=%h p=%h c=%0d want v=%b oh=%h p=%h", i,
                 if_rr.out_valid, if_rr.onehot_out, if_rr.pending, if_rr.pend_cnt, (m_rr.gnt >= 0), e_rr, m_rr.pend);
      end
      total++;
      if ({if_fp.out_valid, if_fp.onehot_out, if_fp.pending, if_fp.pend_cnt} !==
          {(m_fp.gnt >= 0), e_fp, m_fp.pend, 4'($countones(m_fp.pend))}) begin
        bad++;
        $display("FAIL rand_fp cyc=%0d got v=%b oh=%h p=%h c=%0d want v=%b oh=%h p=%h", i,
                 if_fp.out_valid, if_fp.onehot_out, if_fp.pending, if_fp.pend_cnt, (m_fp.gnt >= 0), e_fp, m_fp.pend);
      end
      total++;
      if (if_rr.out_valid && ($countones(if_rr.onehot_out) != 1 || (if_rr.onehot_out & if_rr.pending) == 8'h00)) begin
        bad++;
        $display("FAIL rand_invariant cyc=%0d got oh=%h p=%h want one hot bit inside pending", i, if_rr.onehot_out, if_rr.pending);
      end
      rst = ($urandom_range(0, 63) == 0);
      req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      msk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      rdy = ($urandom_range(0, 2) != 0);
      cyc();
    end
    rst = 1'b0; req = 8'h00; msk = 8'hFF; rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; msk = 8'hFF; rdy = 1'b0;
    test_reset();
    test_single();
    test_rr_fair();
    test_fixed();
    test_mask_stall();
    test_set_wins();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
